// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and constants for the dual-issue dispatcher.
//   instr_cls_e  - instruction class as encoded by decode
//   pipe_sel_e   - issue pipe an instruction is steered to
//   disp_state_e - dispatcher state (EMPTY / PAIR / HOLD)
//   disp_entry_t - one buffered instruction
//   cls_pipe()   - class-based pipe selection

package dispatch_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Storage width of the payload field; the top-level PAYLOAD_W must not exceed it.
    localparam int unsigned DISP_PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        ClsAlu    = 2'b00,
        ClsBranch = 2'b01,
        ClsLoad   = 2'b10,
        ClsStore  = 2'b11
    } instr_cls_e;

    typedef enum logic [1:0] {
        PipeNone = 2'd0,
        PipeBr   = 2'd1,
        PipeMem  = 2'd2
    } pipe_sel_e;

    typedef logic [1:0] disp_state_e;
    localparam disp_state_e StEmpty = 2'd0;
    localparam disp_state_e StPair  = 2'd1;
    localparam disp_state_e StHold  = 2'd2;

    typedef struct packed {
        logic [DISP_PAYLOAD_W-1:0] payload;
        instr_cls_e                cls;
        logic [4:0]                rd;
        logic [4:0]                rs1;
        logic [4:0]                rs2;
        logic                      rf_we;
    } disp_entry_t;

    // ALU ops prefer the branch pipe and spill to the memory pipe when it is taken.
    function automatic pipe_sel_e cls_pipe(instr_cls_e cls, logic br_taken);
        pipe_sel_e sel;
        unique case (cls)
            ClsLoad, ClsStore: sel = PipeMem;
            ClsBranch:         sel = PipeBr;
            default:           sel = br_taken ? PipeMem : PipeBr;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dispatch_steer.sv
// dispatch_steer: combinational pipe steering for the OLD/YNG entry pair.
//   old_*_i / yng_*_i - the entry fields steering depends on, plus valid bits
//   old_sel_o         - pipe for OLD (PipeNone when invalid)
//   yng_sel_o         - pipe for YNG, accounting for OLD's choice
//   conflict_o        - both valid and YNG must wait (same pipe or RAW on OLD.rd)

module dispatch_steer
    import dispatch_pkg::*;
(
    input  logic       old_vld_i,
    input  instr_cls_e old_cls_i,
    input  logic [4:0] old_rd_i,
    input  logic       old_rf_we_i,
    input  logic       yng_vld_i,
    input  instr_cls_e yng_cls_i,
    input  logic [4:0] yng_rs1_i,
    input  logic [4:0] yng_rs2_i,
    output pipe_sel_e  old_sel_o,
    output pipe_sel_e  yng_sel_o,
    output logic       conflict_o
);

    logic raw;

    always_comb begin
        old_sel_o  = old_vld_i ? cls_pipe(old_cls_i, 1'b0) : PipeNone;
        yng_sel_o  = yng_vld_i ? cls_pipe(yng_cls_i, old_sel_o == PipeBr) : PipeNone;
        raw        = old_rf_we_i && (old_rd_i != REG_ZERO) &&
                     ((old_rd_i == yng_rs1_i) || (old_rd_i == yng_rs2_i));
        conflict_o = old_vld_i && yng_vld_i && ((old_sel_o == yng_sel_o) || raw);
    end

endmodule

// File: rtl/dual_issue_dispatch.sv
// dual_issue_dispatch: issue-stage dispatcher. Buffers an in-order pair from decode
// (OLD, YNG), steers each to the branch or memory pipe, serializes YNG on a
// structural or RAW conflict, and honours per-pipe stalls and the issue flush.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   dec_*                       - decode pair (slot 0 older), dec_ready handshake
//   stall_issue_*, flush_issue  - hazard unit controls
//   br_*, mem_*                 - per-pipe presented instruction (zeros when idle)
// Optional: define DISPATCH_PERF_CNT_EN to add saturating perf counters
//   perf_dual_cnt, perf_serial_cnt, perf_stall_cnt.

module dual_issue_dispatch
    import dispatch_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                dec_valid,
    input  logic [1:0][PAYLOAD_W-1:0] dec_payload,
    input  logic [1:0][1:0]           dec_cls,
    input  logic [1:0][4:0]           dec_rd,
    input  logic [1:0][4:0]           dec_rs1,
    input  logic [1:0][4:0]           dec_rs2,
    input  logic [1:0]                dec_rf_we,
    output logic                      dec_ready,
    input  logic                      stall_issue_branch,
    input  logic                      stall_issue_memory,
    input  logic                      flush_issue,
    output logic                      br_valid,
    output logic [PAYLOAD_W-1:0]      br_payload,
    output logic [4:0]                br_rd,
    output logic [4:0]                br_rs1,
    output logic [4:0]                br_rs2,
    output logic                      br_rf_we,
    output logic                      mem_valid,
    output logic [PAYLOAD_W-1:0]      mem_payload,
    output logic [4:0]                mem_rd,
    output logic [4:0]                mem_rs1,
    output logic [4:0]                mem_rs2,
    output logic                      mem_rf_we
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          perf_dual_cnt,
    output logic [CNT_W-1:0]          perf_serial_cnt,
    output logic [CNT_W-1:0]          perf_stall_cnt
`endif
);

    disp_state_e state_q, state_d;
    disp_entry_t old_q, old_d, yng_q, yng_d;
    logic        old_vld_q, old_vld_d, yng_vld_q, yng_vld_d;
    // YNG presented on a pipe but left stalled after OLD issued: keep that pipe.
    logic        yng_lock_q, yng_lock_d;
    pipe_sel_e   yng_lock_sel_q, yng_lock_sel_d;

    disp_entry_t [1:0] new_entry;
    pipe_sel_e   old_sel, yng_sel, yng_sel_eff;
    logic        conflict;
    logic        old_pres, old_fire, yng_pres, yng_fire, all_fire, ready, accept;
    disp_entry_t br_entry, mem_entry;

    function automatic logic pipe_stall(pipe_sel_e sel, logic st_br, logic st_mem);
        logic s;
        unique case (sel)
            PipeBr:  s = st_br;
            PipeMem: s = st_mem;
            default: s = 1'b1;
        endcase
        return s;
    endfunction

    dispatch_steer u_steer (
        .old_vld_i   (old_vld_q),
        .old_cls_i   (old_q.cls),
        .old_rd_i    (old_q.rd),
        .old_rf_we_i (old_q.rf_we),
        .yng_vld_i   (yng_vld_q),
        .yng_cls_i   (yng_q.cls),
        .yng_rs1_i   (yng_q.rs1),
        .yng_rs2_i   (yng_q.rs2),
        .old_sel_o   (old_sel),
        .yng_sel_o   (yng_sel),
        .conflict_o  (conflict)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            new_entry[i].payload = DISP_PAYLOAD_W'(dec_payload[i]);
            new_entry[i].cls     = instr_cls_e'(dec_cls[i]);
            new_entry[i].rd      = dec_rd[i];
            new_entry[i].rs1     = dec_rs1[i];
            new_entry[i].rs2     = dec_rs2[i];
            new_entry[i].rf_we   = dec_rf_we[i];
        end
    end

    // Fire/ready logic. YNG may only go when OLD is issuing now or already gone.
    always_comb begin
        old_pres    = old_vld_q & ~flush_issue;
        old_fire    = old_pres & ~pipe_stall(old_sel, stall_issue_branch, stall_issue_memory);
        yng_sel_eff = (!old_vld_q && yng_lock_q) ? yng_lock_sel_q : yng_sel;
        yng_pres    = yng_vld_q & ~flush_issue & (~old_vld_q | (old_fire & ~conflict));
        yng_fire    = yng_pres &
                      ~pipe_stall(yng_sel_eff, stall_issue_branch, stall_issue_memory);
        all_fire    = (~old_vld_q | old_fire) & (~yng_vld_q | yng_fire);
        ready       = rst_n & ~flush_issue & all_fire;
        accept      = ready & (|dec_valid);
    end

    assign dec_ready = ready;

    always_comb begin
        br_entry  = '0;
        mem_entry = '0;
        br_valid  = 1'b0;
        mem_valid = 1'b0;
        if (old_pres && old_sel == PipeBr) begin
            br_valid = 1'b1;
            br_entry = old_q;
        end else if (yng_pres && yng_sel_eff == PipeBr) begin
            br_valid = 1'b1;
            br_entry = yng_q;
        end
        if (old_pres && old_sel == PipeMem) begin
            mem_valid = 1'b1;
            mem_entry = old_q;
        end else if (yng_pres && yng_sel_eff == PipeMem) begin
            mem_valid = 1'b1;
            mem_entry = yng_q;
        end
    end

    assign br_payload  = br_entry.payload[PAYLOAD_W-1:0];
    assign br_rd       = br_entry.rd;
    assign br_rs1      = br_entry.rs1;
    assign br_rs2      = br_entry.rs2;
    assign br_rf_we    = br_entry.rf_we;
    assign mem_payload = mem_entry.payload[PAYLOAD_W-1:0];
    assign mem_rd      = mem_entry.rd;
    assign mem_rs1     = mem_entry.rs1;
    assign mem_rs2     = mem_entry.rs2;
    assign mem_rf_we   = mem_entry.rf_we;

    always_comb begin
        state_d        = state_q;
        old_d          = old_q;
        yng_d          = yng_q;
        old_vld_d      = old_vld_q & ~old_fire;
        yng_vld_d      = yng_vld_q & ~yng_fire;
        yng_lock_d     = yng_lock_q;
        yng_lock_sel_d = yng_lock_sel_q;

        unique case (state_q)
            StEmpty: if (accept) state_d = StPair;
            StPair: begin
                if (accept)        state_d = StPair;
                else if (all_fire) state_d = StEmpty;
                else if (old_fire) state_d = StHold;
            end
            StHold: begin
                if (accept)        state_d = StPair;
                else if (yng_fire) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase

        if (old_fire && yng_vld_q && !yng_fire) begin
            yng_lock_d     = yng_pres;
            yng_lock_sel_d = yng_sel_eff;
        end

        if (accept) begin
            // A lone slot-1 instruction is compacted into OLD.
            old_d      = dec_valid[0] ? new_entry[0] : new_entry[1];
            yng_d      = new_entry[1];
            old_vld_d  = 1'b1;
            yng_vld_d  = dec_valid[0] & dec_valid[1];
            yng_lock_d = 1'b0;
        end

        if (flush_issue) begin
            state_d    = StEmpty;
            old_vld_d  = 1'b0;
            yng_vld_d  = 1'b0;
            yng_lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StEmpty;
            old_q          <= '0;
            yng_q          <= '0;
            old_vld_q      <= 1'b0;
            yng_vld_q      <= 1'b0;
            yng_lock_q     <= 1'b0;
            yng_lock_sel_q <= PipeNone;
        end else begin
            state_q        <= state_d;
            old_q          <= old_d;
            yng_q          <= yng_d;
            old_vld_q      <= old_vld_d;
            yng_vld_q      <= yng_vld_d;
            yng_lock_q     <= yng_lock_d;
            yng_lock_sel_q <= yng_lock_sel_d;
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [CNT_W-1:0] dual_q, dual_d, serial_q, serial_d, stall_q, stall_d;
    logic             inc_dual, inc_serial, inc_stall;

    always_comb begin
        inc_dual   = br_valid & ~stall_issue_branch & mem_valid & ~stall_issue_memory;
        inc_serial = (state_q == StHold) & ~flush_issue;
        inc_stall  = (old_pres & ~old_fire) | (yng_pres & ~yng_fire);
        dual_d     = (inc_dual && dual_q != '1) ? dual_q + 1'b1 : dual_q;
        serial_d   = (inc_serial && serial_q != '1) ? serial_q + 1'b1 : serial_q;
        stall_d    = (inc_stall && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dual_q   <= '0;
            serial_q <= '0;
            stall_q  <= '0;
        end else begin
            dual_q   <= dual_d;
            serial_q <= serial_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_dual_cnt   = dual_q;
    assign perf_serial_cnt = serial_q;
    assign perf_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_dual_issue_dispatch.sv
module tb_dual_issue_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       dec_valid;
    logic [1:0][63:0] dec_payload;
    logic [1:0][1:0]  dec_cls;
    logic [1:0][4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [1:0]       dec_rf_we;
    logic             dec_ready;
    logic             stall_issue_branch, stall_issue_memory, flush_issue;
    logic             br_valid, mem_valid, br_rf_we, mem_rf_we;
    logic [63:0]      br_payload, mem_payload;
    logic [4:0]       br_rd, br_rs1, br_rs2, mem_rd, mem_rs1, mem_rs2;

    dual_issue_dispatch #(.PAYLOAD_W(64), .CNT_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dec_valid          (dec_valid),
        .dec_payload        (dec_payload),
        .dec_cls            (dec_cls),
        .dec_rd             (dec_rd),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_rf_we          (dec_rf_we),
        .dec_ready          (dec_ready),
        .stall_issue_branch (stall_issue_branch),
        .stall_issue_memory (stall_issue_memory),
        .flush_issue        (flush_issue),
        .br_valid           (br_valid),
        .br_payload         (br_payload),
        .br_rd              (br_rd),
        .br_rs1             (br_rs1),
        .br_rs2             (br_rs2),
        .br_rf_we           (br_rf_we),
        .mem_valid          (mem_valid),
        .mem_payload        (mem_payload),
        .mem_rd             (mem_rd),
        .mem_rs1            (mem_rs1),
        .mem_rs2            (mem_rs2),
        .mem_rf_we          (mem_rf_we)
    );

    // Reference model: an in-order queue of waiting instructions. pin records a pipe
    // an instruction was already shown on (it must stay there until it issues).
    typedef struct {
        logic [63:0] pl;
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic        we;
        int          pin;
    } ins_t;

    ins_t q[$];
    ins_t cur[2];
    int   n_chk = 0;
    int   n_bad = 0;

    logic        exp_bv, exp_mv, exp_rdy;
    logic [63:0] exp_bp, exp_mp;
    logic [15:0] exp_bm, exp_mm;
    bit          h_fire, s_fire;
    int          s_pipe;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 1 = branch pipe, 2 = memory pipe
    function automatic int pipe_of(logic [1:0] cls, bit br_busy);
        if (cls == 2'b10 || cls == 2'b11) return 2;
        if (cls == 2'b01) return 1;
        return br_busy ? 2 : 1;
    endfunction

    function automatic bit pipe_stalled(int p);
        return (p == 1) ? stall_issue_branch : stall_issue_memory;
    endfunction

    task automatic show(input ins_t e, input int p);
        if (p == 1) begin
            exp_bv = 1'b1; exp_bp = e.pl; exp_bm = {e.we, e.rd, e.rs1, e.rs2};
        end else begin
            exp_mv = 1'b1; exp_mp = e.pl; exp_mm = {e.we, e.rd, e.rs1, e.rs2};
        end
    endtask

    task automatic model_eval();
        int  hp, sp;
        bit  raw;
        exp_bv = 0; exp_mv = 0; exp_rdy = 0;
        exp_bp = 0; exp_mp = 0; exp_bm = 0; exp_mm = 0;
        h_fire = 0; s_fire = 0; s_pipe = 0;
        if (!flush_issue) begin
            if (q.size() > 0) begin
                hp = (q[0].pin != 0) ? q[0].pin : pipe_of(q[0].cls, 1'b0);
                show(q[0], hp);
                h_fire = !pipe_stalled(hp);
                if (q.size() > 1) begin
                    sp  = pipe_of(q[1].cls, hp == 1);
                    raw = q[0].we && q[0].rd != 5'd0 &&
                          (q[0].rd == q[1].rs1 || q[0].rd == q[1].rs2);
                    if (h_fire && sp != hp && !raw) begin
                        show(q[1], sp);
                        s_pipe = sp;
                        s_fire = !pipe_stalled(sp);
                    end
                end
            end
            exp_rdy = (q.size() == 0) || (h_fire && (q.size() == 1 || s_fire));
        end
    endtask

    task automatic model_step();
        ins_t t;
        if (flush_issue) begin
            q.delete();
        end else begin
            if (h_fire) begin
                void'(q.pop_front());
                if (s_fire) begin
                    void'(q.pop_front());
                end else if (q.size() > 0 && s_pipe != 0) begin
                    t = q.pop_front();
                    t.pin = s_pipe;
                    q.push_front(t);
                end
            end
            if (exp_rdy) begin
                for (int i = 0; i < 2; i++) if (dec_valid[i]) q.push_back(cur[i]);
            end
        end
    endtask

    task automatic slot(input int i, input logic [1:0] c, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic we);
        cur[i].pl  = {$urandom, $urandom};
        cur[i].cls = c;
        cur[i].rd  = rd;
        cur[i].rs1 = rs1;
        cur[i].rs2 = rs2;
        cur[i].we  = we;
        cur[i].pin = 0;
        dec_payload[i] = cur[i].pl;
        dec_cls[i]     = c;
        dec_rd[i]      = rd;
        dec_rs1[i]     = rs1;
        dec_rs2[i]     = rs2;
        dec_rf_we[i]   = we;
    endtask

    task automatic idle();
        dec_valid          = 2'b00;
        stall_issue_branch = 1'b0;
        stall_issue_memory = 1'b0;
        flush_issue        = 1'b0;
    endtask

    // Called at a negedge with inputs applied; checks, then advances one clock.
    task automatic cycle();
        #1;
        model_eval();
        check_val("br_valid", 64'(br_valid), 64'(exp_bv));
        check_val("mem_valid", 64'(mem_valid), 64'(exp_mv));
        check_val("br_payload", br_payload, exp_bp);
        check_val("mem_payload", mem_payload, exp_mp);
        check_val("br_fields", 64'({br_rf_we, br_rd, br_rs1, br_rs2}), 64'(exp_bm));
        check_val("mem_fields", 64'({mem_rf_we, mem_rd, mem_rs1, mem_rs2}), 64'(exp_mm));
        check_val("dec_ready", 64'(dec_ready), 64'(exp_rdy));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_br_valid"}, 64'(br_valid), 64'd0);
        check_val({pfx, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check_val({pfx, "_br_payload"}, br_payload, 64'd0);
        check_val({pfx, "_mem_payload"}, mem_payload, 64'd0);
        check_val({pfx, "_mem_fields"}, 64'({mem_rf_we, mem_rd, mem_rs1, mem_rs2}), 64'd0);
        check_val({pfx, "_dec_ready"}, 64'(dec_ready), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) slot(i, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // ALU(rd=x5) + LOAD(rs1=x6): dual issue
        slot(0, 2'b00, 5'd5, 5'd1, 5'd2, 1'b1);
        slot(1, 2'b10, 5'd8, 5'd6, 5'd0, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); cycle(); cycle();

        // LOAD + STORE: serialized on the memory pipe
        slot(0, 2'b10, 5'd9, 5'd1, 5'd0, 1'b1);
        slot(1, 2'b11, 5'd0, 5'd2, 5'd3, 1'b0);
        dec_valid = 2'b11; cycle();
        idle(); cycle(); cycle(); cycle();

        // ALU(rd=x7) + ALU(rs2=x7): RAW, then the same with rd=x0
        slot(0, 2'b00, 5'd7, 5'd1, 5'd2, 1'b1);
        slot(1, 2'b00, 5'd3, 5'd4, 5'd7, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); cycle(); cycle();
        slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b1);
        slot(1, 2'b00, 5'd3, 5'd4, 5'd0, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); cycle(); cycle();

        // LOAD old + ALU young, memory pipe stalled 3 cycles
        slot(0, 2'b10, 5'd10, 5'd1, 5'd2, 1'b1);
        slot(1, 2'b00, 5'd11, 5'd3, 5'd4, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); stall_issue_memory = 1'b1;
        cycle(); cycle(); cycle();
        idle(); cycle(); cycle();

        // Lone slot-1 instruction is compacted
        slot(0, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0);
        slot(1, 2'b01, 5'd0, 5'd5, 5'd6, 1'b0);
        dec_valid = 2'b10; cycle();
        idle(); cycle(); cycle();

        // Flush while in HOLD
        slot(0, 2'b10, 5'd9, 5'd1, 5'd0, 1'b1);
        slot(1, 2'b11, 5'd0, 5'd2, 5'd3, 1'b0);
        dec_valid = 2'b11; cycle();
        idle(); stall_issue_memory = 1'b0; cycle();
        stall_issue_memory = 1'b1; flush_issue = 1'b1; cycle();
        idle(); cycle(); cycle();

        // Asynchronous reset in the middle of HOLD
        slot(0, 2'b10, 5'd9, 5'd1, 5'd0, 1'b1);
        slot(1, 2'b11, 5'd4, 5'd2, 5'd3, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        slot(0, 2'b00, 5'd5, 5'd1, 5'd2, 1'b1);
        slot(1, 2'b10, 5'd8, 5'd6, 5'd0, 1'b1);
        dec_valid = 2'b11; cycle();
        idle(); cycle(); cycle();

        // Randomized traffic; small register range to provoke RAW hazards
        for (int n = 0; n < 3000; n++) begin
            dec_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                slot(i, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            end
            stall_issue_branch = ($urandom_range(0, 3) == 0);
            stall_issue_memory = ($urandom_range(0, 3) == 0);
            flush_issue        = ($urandom_range(0, 19) == 0);
            cycle();
        end
        idle(); cycle(); cycle(); cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dual_issue_dispatch.md
Name: dual_issue_dispatch

Overview:
- Issue-stage dispatcher for the dual-issue core.
- Accepts an in-order instruction pair from decode and steers each instruction to either the branch pipeline or the memory pipeline.
- Serializes the pair on a structural or intra-pair RAW conflict.
- Responds to the per-pipe issue stalls and the issue flush driven by the hazard unit. It is the receiving end of that stall/flush protocol.

Parameters:
PAYLOAD_W, 64, opaque per-instruction payload width (pc, imm, control bundle).
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
dec_valid  in  2  decode slot valid; bit0 = older
dec_payload  in  2xPAYLOAD_W  per-slot payload
dec_cls  in  2x2  class: 00 ALU, 01 BRANCH, 10 LOAD, 11 STORE
dec_rd, dec_rs1, dec_rs2  in  2x5 each  register indices
dec_rf_we  in  2  slot writes rd
dec_ready  out  1  dispatcher accepts a pair this cycle
stall_issue_branch  in  1  branch pipe cannot take an instruction
stall_issue_memory  in  1  memory pipe cannot take an instruction
flush_issue  in  1  branch correction; kill everything held
br_valid, mem_valid  out  1 each  instruction presented to the pipe
br_payload, mem_payload  out  PAYLOAD_W each
br_rd, br_rs1, br_rs2, mem_rd, mem_rs1, mem_rs2  out  5 each
br_rf_we, mem_rf_we  out  1 each

Behaviour:
- Storage: 2-entry buffer (OLD, YNG) with valid bits.
- Decode pair compaction: a lone valid slot1 is compacted into OLD.
- Latency: a pair accepted at edge N is presented on the issue ports during cycle N+1.
- Steering, class-based:
  - LOAD/STORE -> memory pipe only.
  - BRANCH -> branch pipe only.
  - ALU -> branch pipe by default; memory pipe if the branch pipe is taken by OLD this cycle.
- Conflict, YNG waits a cycle (state HOLD):
  - both instructions need the same pipe (two mem ops, two branches); or
  - intra-pair RAW: OLD.rf_we, OLD.rd != 0, and OLD.rd equal to YNG.rs1 or YNG.rs2.
- Fire rule: a pipe fires when its valid is high and its stall is low.
- In-order rule: YNG is presented (valid high) only if OLD fires in the same cycle or OLD is already gone.
- Stalled entries keep all outputs stable until they fire.
- State machine:
  - EMPTY: no entries.
  - PAIR: OLD, optionally YNG, presented.
  - HOLD: only YNG remains.
  - EMPTY -> PAIR on accept.
  - PAIR -> EMPTY when all entries fire and no new accept.
  - PAIR -> PAIR on fire-all plus accept.
  - PAIR -> HOLD when OLD fires and YNG does not.
  - HOLD -> EMPTY/PAIR when YNG fires (PAIR if a new pair is accepted).
  - Any state -> EMPTY on flush.
- dec_ready = ~flush_issue & (buffer empty, or every valid entry fires this cycle). It is combinational.
- Flush (flush_issue = 1):
  - br_valid and mem_valid are forced 0 in the same cycle;
  - no accept;
  - buffer cleared at the next edge;
  - flush wins over a simultaneous stall or accept.
- Idle outputs: payload, rd, rs, and rf_we are driven 0 whenever the matching valid is 0.
- Reset (asynchronous, any time, including mid-HOLD):
  - buffer invalid, state EMPTY;
  - all outputs 0 immediately;
  - dec_ready = 1 once rst_n deasserts.

Optional Feature:
DISPATCH_PERF_CNT_EN. When defined, the following are added:
- outputs perf_dual_cnt, perf_serial_cnt, perf_stall_cnt (CNT_W each):
  - perf_dual_cnt: cycles where both pipes fire;
  - perf_serial_cnt: cycles in HOLD;
  - perf_stall_cnt: cycles where any valid entry is blocked by a stall.
- Counters saturate at all-ones, clear on reset, and do not count during flush.

When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- dispatch_pkg:
  - instr_cls_e (ALU/BRANCH/LOAD/STORE);
  - pipe_sel_e (NONE/BR/MEM);
  - disp_state_e (EMPTY/PAIR/HOLD);
  - packed entry struct (payload, cls, rd, rs1, rs2, rf_we);
  - constant REG_ZERO = 5'd0.
- Sub-module dispatch_steer: purely combinational. Takes OLD/YNG entries, returns pipe selects plus a conflict flag.

Test Plan:
- ALU(rd=x5) + LOAD(rs1=x6), no stalls -> next cycle br_valid=1 (ALU), mem_valid=1 (LOAD), dec_ready=1, state EMPTY after.
- LOAD + STORE -> cycle1 mem gets LOAD, br_valid=0, dec_ready=0 (HOLD); cycle2 mem gets STORE, dec_ready=1.
- ALU(rd=x7) + ALU(rs2=x7) -> serialized over 2 cycles. Same pair with rd=x0 -> both issue in one cycle (br + mem).
- LOAD old + ALU young, stall_issue_memory=1 for 3 cycles -> mem_valid=1 stable, br_valid=0 for 3 cycles; cycle 4 both fire.
- flush_issue=1 while in HOLD -> br_valid=mem_valid=0 that cycle, dec_ready=0; next cycle EMPTY, dec_ready=1.
- rst_n pulled low mid-HOLD, between clock edges -> all outputs 0 without a clock edge; after release a new pair issues normally one cycle after accept.
